uart_frame_parser: RTL

//  Parses framed packets from the UART RX byte stream: [opcode][reserved][len_lo][len_hi][payload].
//  len is total bytes incl. 4-byte header, little-endian. ECHO payload passes straight to the TX path.
//  ALU-opcode payloads are packed into WORD_W-bit operands for the ALU. Sits between uart_rx and alu/uart_tx.

---
 rtl/uart_frame_parser.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/uart_frame_parser.sv
// Packet parser between uart_rx and the ALU / uart_tx: header decode, echo pass-through,
// little-endian operand packing, length/opcode checks and inter-byte timeout resync.
module uart_frame_parser #(
    parameter int         WORD_W      = 32,
    parameter int         MAX_LEN     = 64,
    parameter int         TIMEOUT_CYC = 4096,
    parameter logic [7:0] OP_ECHO     = 8'hEC,
    parameter logic [7:0] OP_ADD      = 8'hA0,
    parameter logic [7:0] OP_MUL      = 8'hA1,
    parameter logic [7:0] OP_DIV      = 8'hA2
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [7:0]        rx_data_i,
    input  logic              rx_valid_i,
    output logic              rx_ready_o,
    output logic [7:0]        echo_data_o,
    output logic              echo_valid_o,
    input  logic              echo_ready_i,
    output logic [7:0]        op_o,
    output logic [WORD_W-1:0] operand_o,
    output logic              operand_valid_o,
    output logic              operand_last_o,
    input  logic              operand_ready_i,
    output logic              err_o,
    output logic [1:0]        err_code_o,
    output logic              busy_o
);

    localparam int NB  = WORD_W / 8;
    localparam int BCW = (NB > 1) ? $clog2(NB) : 1;
    localparam int TW  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_RSVD, S_LEN_LO, S_LEN_HI, S_ECHO, S_OPND, S_DRAIN
    } state_e;

    state_e            state_q, state_d;
    logic [7:0]        op_q, op_d;
    logic [7:0]        len_lo_q, len_lo_d;
    logic [15:0]       rem_q, rem_d;
    logic [BCW-1:0]    bc_q, bc_d;
    logic [WORD_W-1:0] shift_q, shift_d;
    logic [WORD_W-1:0] operand_q, operand_d;
    logic              opnd_valid_q, opnd_valid_d;
    logic              opnd_last_q, opnd_last_d;
    logic              err_q, err_d;
    logic [1:0]        err_code_q, err_code_d;
    logic [TW-1:0]     tmo_q, tmo_d;

    logic              rx_ready;
    logic              echo_valid;
    logic              rx_hs;
    logic [15:0]       len_w;
    logic [15:0]       body_w;
    logic              is_opnd;
    logic [WORD_W-1:0] shift_in;

    // Valid/ready: a byte moves on any cycle where valid and ready are both high;
    // a producer holds data stable while valid is high and ready is low.
    always_comb begin
        rx_ready   = 1'b1;
        echo_valid = 1'b0;
        case (state_q)
            S_ECHO: begin
                rx_ready   = echo_ready_i;
                echo_valid = rx_valid_i;
            end
            // Once the final operand is formed no further bytes belong to this packet.
            S_OPND:  rx_ready = (rem_q != 16'd0) && !(opnd_valid_q && !operand_ready_i);
            default: rx_ready = 1'b1;
        endcase
    end

    assign rx_hs    = rx_valid_i & rx_ready;
    assign len_w    = {rx_data_i, len_lo_q};
    assign body_w   = len_w - 16'd4;
    assign is_opnd  = (op_q == OP_ADD) || (op_q == OP_MUL) || (op_q == OP_DIV);
    assign shift_in = WORD_W'({rx_data_i, shift_q} >> 8);

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        len_lo_d     = len_lo_q;
        rem_d        = rem_q;
        bc_d         = bc_q;
        shift_d      = shift_q;
        operand_d    = operand_q;
        opnd_valid_d = opnd_valid_q;
        opnd_last_d  = opnd_last_q;
        err_d        = 1'b0;
        err_code_d   = err_code_q;
        tmo_d        = tmo_q;

        if (opnd_valid_q && operand_ready_i) opnd_valid_d = 1'b0;

        case (state_q)
            S_IDLE: if (rx_hs) begin
                op_d    = rx_data_i;
                state_d = S_RSVD;
            end
            S_RSVD: if (rx_hs) state_d = S_LEN_LO;
            S_LEN_LO: if (rx_hs) begin
                len_lo_d = rx_data_i;
                state_d  = S_LEN_HI;
            end
            S_LEN_HI: if (rx_hs) begin
                rem_d = body_w;
                bc_d  = '0;
                if (len_w < 16'd4 || len_w > 16'(MAX_LEN)) begin
                    err_d      = 1'b1;
                    err_code_d = 2'd2;
                    state_d    = S_IDLE;
                end else if (is_opnd && (body_w == 16'd0 || (body_w % 16'(NB)) != 16'd0)) begin
                    err_d      = 1'b1;
                    err_code_d = 2'd2;
                    state_d    = (body_w == 16'd0) ? S_IDLE : S_DRAIN;
                end else if (!is_opnd && op_q != OP_ECHO) begin
                    err_d      = 1'b1;
                    err_code_d = 2'd1;
                    state_d    = (body_w == 16'd0) ? S_IDLE : S_DRAIN;
                end else if (body_w == 16'd0) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = is_opnd ? S_OPND : S_ECHO;
                end
            end
            S_ECHO, S_DRAIN: if (rx_hs) begin
                rem_d = rem_q - 16'd1;
                if (rem_q == 16'd1) state_d = S_IDLE;
            end
            S_OPND: begin
                if (rx_hs) begin
                    shift_d = shift_in;
                    rem_d   = rem_q - 16'd1;
                    if (bc_q == BCW'(NB - 1)) begin
                        bc_d         = '0;
                        operand_d    = shift_in;
                        opnd_valid_d = 1'b1;
                        opnd_last_d  = (rem_q == 16'd1);
                    end else begin
                        bc_d = bc_q + BCW'(1);
                    end
                end
                if (opnd_valid_q && operand_ready_i && opnd_last_q) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Stalls caused by downstream back-pressure do not count towards the timeout.
        if (state_q == S_IDLE || rx_hs) begin
            tmo_d = '0;
        end else if (TIMEOUT_CYC != 0 && rx_ready) begin
            if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
                state_d      = S_IDLE;
                err_d        = 1'b1;
                err_code_d   = 2'd3;
                opnd_valid_d = 1'b0;
                opnd_last_d  = 1'b0;
                bc_d         = '0;
                tmo_d        = '0;
            end else begin
                tmo_d = tmo_q + TW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= S_IDLE;
            op_q         <= '0;
            len_lo_q     <= '0;
            rem_q        <= '0;
            bc_q         <= '0;
            shift_q      <= '0;
            operand_q    <= '0;
            opnd_valid_q <= 1'b0;
            opnd_last_q  <= 1'b0;
            err_q        <= 1'b0;
            err_code_q   <= '0;
            tmo_q        <= '0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            len_lo_q     <= len_lo_d;
            rem_q        <= rem_d;
            bc_q         <= bc_d;
            shift_q      <= shift_d;
            operand_q    <= operand_d;
            opnd_valid_q <= opnd_valid_d;
            opnd_last_q  <= opnd_last_d;
            err_q        <= err_d;
            err_code_q   <= err_code_d;
            tmo_q        <= tmo_d;
        end
    end

    assign rx_ready_o      = rx_ready;
    assign echo_data_o     = rx_data_i;
    assign echo_valid_o    = echo_valid;
    assign op_o            = op_q;
    assign operand_o       = operand_q;
    assign operand_valid_o = opnd_valid_q;
    assign operand_last_o  = opnd_last_q;
    assign err_o           = err_q;
    assign err_code_o      = err_code_q;
    assign busy_o          = (state_q != S_IDLE);

endmodule
